// File: rtl/shift_add_sequencer.sv
// Register and control stage of the signed shift-add multiplier: owns the X/A/B
// product registers and steps WIDTH add-or-subtract / arithmetic-shift iterations.
module shift_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic [WIDTH-1:0] S,
   output logic [WIDTH-1:0] Aval,
   output logic [WIDTH-1:0] Bval,
   output logic             X,
   output logic             Done
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ADD   = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             run_q;
   logic             start;
   logic             last_iter;
   logic [WIDTH:0]   s_ext;
   logic [WIDTH:0]   xa;
   logic [WIDTH:0]   addsub;

   assign start     = Run & ~run_q;
   assign last_iter = (cnt_q == LAST_CNT);
   assign s_ext     = {S[WIDTH-1], S};
   assign xa        = {x_q, a_q};

   // The multiplier's top bit carries negative weight, so the last partial
   // product is subtracted; the extra X bit keeps -2^(W-1) * -2^(W-1) exact.
   always_comb begin
      addsub = xa + s_ext;
      if (last_iter) begin
         addsub = xa - s_ext;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (ClearA_LoadB) begin
               x_d = 1'b0;
               a_d = '0;
               b_d = S;
            end else if (start) begin
               x_d     = 1'b0;
               a_d     = '0;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            if (b_q[0]) begin
               {x_d, a_d} = addsub;
            end
            state_d = SHIFT;
         end
         SHIFT: begin
            {x_d, a_d, b_d} = {x_q, x_q, a_q, b_q[WIDTH-1:1]};
            if (last_iter) begin
               state_d = DONE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ADD;
            end
         end
         DONE: begin
            if (!Run) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // run_q follows Run even during reset, so a level held across reset
   // release is not mistaken for a fresh start request.
   always_ff @(posedge Clk) begin
      run_q <= Run;
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign X    = x_q;
   assign Done = (state_q == DONE);

endmodule
